// File: rtl/regfile_sb.sv
// Two-read, two-write register file with a busy scoreboard for pending
// memory writebacks. Register 0 is hard-wired to zero and never busy.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [ADDR_W:0]   busy_cnt,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_COLLIDE  = 2'b01,
    ERR_RESERVED = 2'b10,
    ERR_WAW      = 2'b11
  } err_code_e;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  err_code_e         code_nxt;

  logic wa_live, wb_live, rsv_live;
  logic collide, reserved, waw;

  // Any access aimed at register 0 is dropped before it reaches state.
  assign wa_live  = wa_en  && (wa_addr  != '0);
  assign wb_live  = wb_en  && (wb_addr  != '0);
  assign rsv_live = rsv_en && (rsv_addr != '0);

  assign collide  = wa_live && wb_live && (wa_addr == wb_addr);
  assign reserved = rsv_live && busy[rsv_addr] && !(wb_live && (wb_addr == rsv_addr));
  assign waw      = wa_live && busy[wa_addr];

  // NOTE: every variable written in an always_comb gets a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    busy_nxt = busy;
    if (wb_live)  busy_nxt[wb_addr]  = 1'b0;
    // A fresh reservation overrides a same-cycle writeback clear.
    if (rsv_live) busy_nxt[rsv_addr] = 1'b1;
  end

  // Bit 0 can never be set, so the count tops out at DEPTH-1.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 1; i < DEPTH; i++) begin
      cnt_nxt += (ADDR_W + 1)'(busy_nxt[i]);
    end
  end

  always_comb begin
    code_nxt = ERR_NONE;
    if (waw)           code_nxt = ERR_WAW;
    else if (reserved) code_nxt = ERR_RESERVED;
    else if (collide)  code_nxt = ERR_COLLIDE;
  end

  // NOTE: the array sits in flops rather than a RAM macro because reset must
  // clear every entry asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy     <= '0;
      busy_cnt <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      // NOTE: non-blocking assignments here; port B is written last, so on an
      // address collision its data is the one that lands.
      if (wa_live) mem[wa_addr] <= wa_data;
      if (wb_live) mem[wb_addr] <= wb_data;
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
      err      <= (code_nxt != ERR_NONE);
      err_code <= code_nxt;
    end
  end

  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd [2];
  logic              rb [2];

  assign ra[0] = rd_addr1;
  assign ra[1] = rd_addr2;

  // Forwarding is suppressed during reset because the write it would
  // forward is not going to happen.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p] = mem[ra[p]];
      rb[p] = busy[ra[p]];
      if (BYPASS && !rst) begin
        if (wb_live && (wb_addr == ra[p])) begin
          rd[p] = wb_data;
          if (!(rsv_live && (rsv_addr == ra[p]))) rb[p] = 1'b0;
        end else if (wa_live && (wa_addr == ra[p])) begin
          rd[p] = wa_data;
        end
      end
      if (ra[p] == '0) rd[p] = '0;
    end
  end

  assign rd_data1 = rd[0];
  assign rd_data2 = rd[1];
  assign rd_busy1 = rb[0];
  assign rd_busy2 = rb[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a forwarding and a non-forwarding instance share the
// same stimulus and are checked against an array-based model of the rules.
module tb_regfile_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rd_addr1 = '0, rd_addr2 = '0;
  logic          wa_en = 1'b0, wb_en = 1'b0, rsv_en = 1'b0;
  logic [AW-1:0] wa_addr = '0, wb_addr = '0, rsv_addr = '0;
  logic [DW-1:0] wa_data = '0, wb_data = '0;

  logic [DW-1:0] rd_data1_b, rd_data2_b, rd_data1_n, rd_data2_n;
  logic          rd_busy1_b, rd_busy2_b, rd_busy1_n, rd_busy2_n;
  logic [AW:0]   busy_cnt_b, busy_cnt_n;
  logic          err_b, err_n;
  logic [1:0]    err_code_b, err_code_n;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1_b), .rd_data2(rd_data2_b),
    .rd_busy1(rd_busy1_b), .rd_busy2(rd_busy2_b),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_cnt(busy_cnt_b), .err(err_b), .err_code(err_code_b)
  );

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b0)) dut_n (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1_n), .rd_data2(rd_data2_n),
    .rd_busy1(rd_busy1_n), .rd_busy2(rd_busy2_n),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_cnt(busy_cnt_n), .err(err_n), .err_code(err_code_n)
  );

  always #5 clk = ~clk;

  bit [DW-1:0] m_regs [DEPTH];
  bit          m_busy [DEPTH];
  bit          m_err;
  bit [1:0]    m_code;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    foreach (m_regs[i]) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_err  = 1'b0;
    m_code = 2'b00;
  endfunction

  function automatic int m_count();
    int c = 0;
    foreach (m_busy[i]) c += int'(m_busy[i]);
    return c;
  endfunction

  // Applies one clock edge to the model using the inputs currently driven.
  function automatic void m_edge();
    bit col, dup, hz;
    col = wa_en && wb_en && (wa_addr == wb_addr) && (wa_addr != '0);
    dup = rsv_en && (rsv_addr != '0) && m_busy[rsv_addr] && !(wb_en && (wb_addr == rsv_addr));
    hz  = wa_en && (wa_addr != '0) && m_busy[wa_addr];
    m_err  = col || dup || hz;
    m_code = hz ? 2'b11 : dup ? 2'b10 : col ? 2'b01 : 2'b00;
    if (wa_en && (wa_addr != '0)) m_regs[wa_addr] = wa_data;
    if (wb_en && (wb_addr != '0)) begin
      m_regs[wb_addr] = wb_data;
      m_busy[wb_addr] = 1'b0;
    end
    if (rsv_en && (rsv_addr != '0)) m_busy[rsv_addr] = 1'b1;
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
    if (a == '0) return '0;
    if (byp && wb_en && (wb_addr == a)) return wb_data;
    if (byp && wa_en && (wa_addr == a)) return wa_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    if (byp && wb_en && (wb_addr == a) && !(rsv_en && (rsv_addr == a))) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic check_reads(input string tag);
    check({tag, "_d1_byp"}, 64'(rd_data1_b), 64'(exp_data(rd_addr1, 1'b1)));
    check({tag, "_d2_byp"}, 64'(rd_data2_b), 64'(exp_data(rd_addr2, 1'b1)));
    check({tag, "_b1_byp"}, 64'(rd_busy1_b), 64'(exp_busy(rd_addr1, 1'b1)));
    check({tag, "_b2_byp"}, 64'(rd_busy2_b), 64'(exp_busy(rd_addr2, 1'b1)));
    check({tag, "_d1_nob"}, 64'(rd_data1_n), 64'(exp_data(rd_addr1, 1'b0)));
    check({tag, "_d2_nob"}, 64'(rd_data2_n), 64'(exp_data(rd_addr2, 1'b0)));
    check({tag, "_b1_nob"}, 64'(rd_busy1_n), 64'(exp_busy(rd_addr1, 1'b0)));
    check({tag, "_b2_nob"}, 64'(rd_busy2_n), 64'(exp_busy(rd_addr2, 1'b0)));
  endtask

  task automatic check_state(input string tag);
    check({tag, "_cnt_byp"}, 64'(busy_cnt_b), 64'(m_count()));
    check({tag, "_cnt_nob"}, 64'(busy_cnt_n), 64'(m_count()));
    check({tag, "_err_byp"}, 64'(err_b), 64'(m_err));
    check({tag, "_err_nob"}, 64'(err_n), 64'(m_err));
    if (m_err) begin
      check({tag, "_code_byp"}, 64'(err_code_b), 64'(m_code));
      check({tag, "_code_nob"}, 64'(err_code_n), 64'(m_code));
    end
  endtask

  task automatic idle();
    wa_en  = 1'b0;
    wb_en  = 1'b0;
    rsv_en = 1'b0;
  endtask

  // Inputs are already driven: check reads before the edge, clock once,
  // drop the enables, then check registered state and settled reads.
  task automatic step(input string tag);
    #1;
    check_reads({tag, "_pre"});
    @(posedge clk);
    m_edge();
    #1;
    idle();
    #1;
    check_state(tag);
    check_reads({tag, "_post"});
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    m_reset();
    rd_addr1 = 5'd5;
    rd_addr2 = 5'd31;
    #2;
    check_reads("reset");
    check_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // Write on port A with a same-cycle read of that address.
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'hDEADBEEF; rd_addr1 = 5'd3;
    #1;
    check("bypass_same_cycle", 64'(rd_data1_b), 64'(32'hDEADBEEF));
    check("nobypass_pre_edge", 64'(rd_data1_n), 64'(0));
    step("wr3");
    check("bypass_after_edge", 64'(rd_data1_b), 64'(32'hDEADBEEF));
    check("nobypass_after_edge", 64'(rd_data1_n), 64'(32'hDEADBEEF));

    // Register 0 ignores writeback and reservation.
    wb_en = 1'b1; wb_addr = '0; wb_data = 32'h1234; rsv_en = 1'b1; rsv_addr = '0;
    rd_addr1 = '0;
    step("reg0");
    check("reg0_data", 64'(rd_data1_b), 64'(0));
    check("reg0_cnt", 64'(busy_cnt_b), 64'(0));
    check("reg0_err", 64'(err_b), 64'(0));

    // Scoreboard reservations and writeback release.
    rsv_en = 1'b1; rsv_addr = 5'd7; step("rsv7");
    rsv_en = 1'b1; rsv_addr = 5'd9; rd_addr1 = 5'd7; step("rsv9");
    check("sb_cnt2", 64'(busy_cnt_b), 64'(2));
    check("sb_busy7", 64'(rd_busy1_b), 64'(1));
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h55; step("wb7");
    check("sb_cnt1", 64'(busy_cnt_b), 64'(1));
    check("sb_data7", 64'(rd_data1_b), 64'(32'h55));
    rsv_en = 1'b1; rsv_addr = 5'd9; step("rersv9");
    check("rersv_err", 64'(err_b), 64'(1));
    check("rersv_code", 64'(err_code_b), 64'(2'b10));
    step("rersv_idle");
    check("rersv_err_clears", 64'(err_b), 64'(0));

    // Same-address dual write, then WAW on a busy register.
    wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'hA;
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'hB; rd_addr1 = 5'd4;
    step("collide");
    check("collide_data", 64'(rd_data1_b), 64'(32'hB));
    check("collide_code", 64'(err_code_b), 64'(2'b01));
    wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'h99; rd_addr1 = 5'd9;
    step("waw");
    check("waw_data", 64'(rd_data1_b), 64'(32'h99));
    check("waw_code", 64'(err_code_b), 64'(2'b11));
    check("waw_cnt", 64'(busy_cnt_b), 64'(1));

    for (int i = 0; i < 400; i++) begin
      wa_en    = 1'($urandom_range(0, 1));
      wa_addr  = rand_addr();
      wa_data  = DW'($urandom());
      wb_en    = 1'($urandom_range(0, 1));
      wb_addr  = rand_addr();
      wb_data  = DW'($urandom());
      rsv_en   = 1'($urandom_range(0, 1));
      rsv_addr = rand_addr();
      rd_addr1 = rand_addr();
      rd_addr2 = rand_addr();
      step("rand");
    end

    // Asynchronous reset between edges with three registers reserved.
    rst = 1'b1;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    rsv_en = 1'b1; rsv_addr = 5'd10; step("ar_rsv10");
    rsv_en = 1'b1; rsv_addr = 5'd11; step("ar_rsv11");
    rsv_en = 1'b1; rsv_addr = 5'd12; step("ar_rsv12");
    check("ar_cnt3", 64'(busy_cnt_b), 64'(3));
    rst = 1'b1;
    m_reset();
    #1;
    check("ar_cnt0_byp", 64'(busy_cnt_b), 64'(0));
    check("ar_cnt0_nob", 64'(busy_cnt_n), 64'(0));
    wa_en = 1'b1; wa_addr = 5'd6; wa_data = 32'h66; rsv_en = 1'b1; rsv_addr = 5'd6;
    @(posedge clk);
    #1;
    idle();
    for (int i = 0; i < DEPTH / 2; i++) begin
      rd_addr1 = AW'(i);
      rd_addr2 = AW'(i + DEPTH / 2);
      #1;
      check_reads("ar_sweep");
    end
    @(negedge clk);
    rst = 1'b0;
    rsv_en = 1'b1; rsv_addr = 5'd5; rd_addr1 = 5'd6; step("ar_first_edge");
    check("ar_first_cnt", 64'(busy_cnt_b), 64'(1));
    check("ar_reg6_ignored", 64'(rd_data1_b), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = reads return array contents only.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, input, 1, rising-edge clock.
- rst, input, 1, reset: asynchronous, active-high.
- rd_addr1, input, ADDR_W, read port 1 address.
- rd_addr2, input, ADDR_W, read port 2 address.
- rd_data1, output, DATA_W, read port 1 data.
- rd_data2, output, DATA_W, read port 2 data.
- rd_busy1, output, 1, register at rd_addr1 awaits writeback.
- rd_busy2, output, 1, register at rd_addr2 awaits writeback.
- wa_en / wa_addr / wa_data, input, 1 / ADDR_W / DATA_W, write port A (ALU result).
- wb_en / wb_addr / wb_data, input, 1 / ADDR_W / DATA_W, write port B (memory writeback; clears busy).
- rsv_en / rsv_addr, input, 1 / ADDR_W, reserve a register for a pending port-B writeback.
- busy_cnt, output, ADDR_W+1, number of busy registers.
- err, output, 1, one-cycle error pulse.
- err_code, output, 2, error cause; valid while err=1.

Function
REQ-003 Register 0 SHALL read as 0, SHALL ignore all writes, and SHALL never become busy; rsv_en to address 0 SHALL have no effect.
REQ-004 Writes SHALL occur at the rising edge of clk when the port enable is 1.
REQ-005 When wa_en and wb_en target the same nonzero address in one cycle, port B data SHALL be stored, and err SHALL pulse with err_code=2'b01.
REQ-006 Reads SHALL be combinational from rd_addrN with zero latency.
REQ-007 With BYPASS=1, a read whose address matches an enabled nonzero write in the same cycle SHALL return the write data, port B taking priority over port A.
REQ-008 With BYPASS=0, a read SHALL return the pre-edge array value.
REQ-009 Each register SHALL carry a busy bit; rsv_en=1 SHALL set busy[rsv_addr] at the clock edge.
REQ-010 wb_en=1 SHALL clear busy[wb_addr] at the clock edge.
REQ-011 If rsv_en and wb_en target the same address in one cycle, the data SHALL be written and busy SHALL end at 1 (the new reservation wins).
REQ-012 rsv_en to an already-busy register, not cleared in the same cycle, SHALL leave busy=1 and pulse err with err_code=2'b10.
REQ-013 wa_en to a busy register SHALL still write the data, SHALL leave busy unchanged, and SHALL pulse err with err_code=2'b11 (WAW hazard).
REQ-014 wb_en to a non-busy nonzero register SHALL write the data; this SHALL NOT be an error.
REQ-015 rd_busyN SHALL equal busy[rd_addrN], except with BYPASS=1 where it SHALL read 0 if wb_en clears that address in the same cycle and rsv_en does not set it.
REQ-016 busy_cnt SHALL be a registered count of set busy bits and SHALL be updated at the same edge as the busy bits; it SHALL never exceed 2**ADDR_W-1.
REQ-017 err and err_code SHALL be registered and SHALL assert for exactly one cycle after the offending edge.
REQ-018 When multiple errors coincide, err_code priority SHALL be 2'b11 > 2'b10 > 2'b01.
REQ-019 The block SHALL behave correctly for any DATA_W ≥ 1 and ADDR_W ≥ 1.

Reset
REQ-020 rst=1 SHALL immediately, independent of clk, clear all registers, all busy bits, busy_cnt, err and err_code to 0.
REQ-021 While rst=1, writes and reservations SHALL be ignored.
REQ-022 Reset asserted mid-reservation SHALL discard all pending busy state; the first edge after rst falls SHALL operate normally.

Verification
REQ-023 Reset then read: rst pulse, rd_addr1=5, rd_addr2=31 -> rd_data1=0, rd_data2=0, busy_cnt=0, err=0.
REQ-024 Write and bypass: wa_en=1, wa_addr=3, wa_data=32'hDEADBEEF, rd_addr1=3, BYPASS=1 -> rd_data1=32'hDEADBEEF in the same cycle and after the edge; with BYPASS=0 -> 0 before the edge, 32'hDEADBEEF after.
REQ-025 Register 0: wb_en=1, wb_addr=0, wb_data=32'h1234, plus rsv_en=1, rsv_addr=0 -> rd_data1 at address 0 stays 0, busy_cnt stays 0, err=0.
REQ-026 Scoreboard: rsv 7, then rsv 9 -> busy_cnt=2 and rd_busy1=1 at address 7; wb_en to 7 with data 32'h55 -> busy_cnt=1, rd_data1=32'h55; re-reserve 9 -> err=1, err_code=2'b10 for one cycle.
REQ-027 Collisions: wa and wb both to address 4 with data 32'hA / 32'hB -> stored 32'hB, err_code=2'b01; wa to busy address 9 -> data written, err_code=2'b11, busy_cnt unchanged.
REQ-028 Async reset: assert rst between clock edges while busy_cnt=3 -> busy_cnt=0 and all data 0 before the next edge.
